// File: rtl/contador_programable_pkg.sv
// Shared types and defaults for the programmable up/down modulo counter.
// Imported by the counter and by anything that needs its state encoding.
package contador_programable_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_FIN_CUENTA = 10;

endpackage

// File: rtl/contador_programable.sv
// Up/down modulo counter with run-time modulus, preload, cascade carry,
// wrap/one-shot modes and a registered wrap pulse.
module contador_programable
    import contador_programable_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned FIN_CUENTA = DEF_FIN_CUENTA
) (
    input  logic             iCLOCK,
    input  logic             iRESET,
    input  logic             iENABLE,
    input  logic             iCARRY_IN,
    input  logic             iUP_DOWN,
    input  logic             iONE_SHOT,
    input  logic             iLOAD,
    input  logic [WIDTH-1:0] iLOAD_MOD,
    input  logic [WIDTH-1:0] iLOAD_VAL,
    output logic [WIDTH-1:0] oCOUNT,
    output logic             oTC,
    output logic             oCARRY_OUT,
    output logic             oWRAP,
    output logic             oDONE
);

    localparam logic [WIDTH-1:0] FIN = WIDTH'(FIN_CUENTA);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] mod_q;
    state_e           state_q;
    logic             wrap_q;

    logic [WIDTH-1:0] top_d;
    logic [WIDTH-1:0] step_d;
    logic [WIDTH-1:0] lmod_d;
    logic [WIDTH-1:0] lval_d;
    logic             en_d;
    logic             tc_d;
    logic             live_d;

    function automatic logic [WIDTH-1:0] clamp_val(
        input logic [WIDTH-1:0] val,
        input logic [WIDTH-1:0] modv
    );
        logic [WIDTH-1:0] lim;
        lim = modv - ONE;
        return (val > lim) ? lim : val;
    endfunction

    always_comb begin
        top_d  = mod_q - ONE;
        en_d   = iENABLE & iCARRY_IN;
        tc_d   = iUP_DOWN ? (count_q == top_d) : (count_q == '0);
        live_d = en_d & tc_d & (state_q == RUN);
        lmod_d = (iLOAD_MOD == '0) ? ONE : iLOAD_MOD;
        lval_d = clamp_val(iLOAD_VAL, lmod_d);
        // Out-of-range counts take the terminal step in either direction.
        if (iUP_DOWN) begin
            step_d = (count_q >= top_d) ? '0 : count_q + ONE;
        end else begin
            step_d = (count_q == '0 || count_q >= mod_q) ? top_d
                                                         : count_q - ONE;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            count_q <= '0;
            mod_q   <= FIN;
            state_q <= RUN;
            wrap_q  <= 1'b0;
        end else if (iLOAD) begin
            mod_q   <= lmod_d;
            count_q <= lval_d;
            state_q <= RUN;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= live_d;
            unique case (state_q)
                RUN: begin
                    if (en_d) begin
                        if (iONE_SHOT && tc_d) begin
                            state_q <= HALT;
                        end else begin
                            count_q <= step_d;
                        end
                    end
                end
                HALT: begin
                    if (!iONE_SHOT) begin
                        state_q <= RUN;
                    end
                end
            endcase
        end
    end

    assign oCOUNT     = count_q;
    assign oTC        = tc_d;
    assign oCARRY_OUT = live_d;
    assign oWRAP      = wrap_q;
    assign oDONE      = (state_q == HALT);

endmodule

// File: tb/tb_contador_programable.sv
// Scoreboard bench: arithmetic reference model feeds an expectation queue,
// a negedge monitor pops and compares against the counters.
module tb_contador_programable;

    localparam int W   = 8;
    localparam int FIN = 10;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, en, cin, up, os, ld;
    logic [W-1:0] lm, lv;
    logic [W-1:0] cnt;
    logic         tc, co, wrap, done;

    logic         c_rst, c_en;
    logic [W-1:0] lo_cnt, hi_cnt;
    logic         lo_tc, lo_co, lo_wrap, lo_done;
    logic         hi_tc, hi_co, hi_wrap, hi_done;

    contador_programable #(.WIDTH(W), .FIN_CUENTA(FIN)) u_main (
        .iCLOCK(clk), .iRESET(rst), .iENABLE(en), .iCARRY_IN(cin),
        .iUP_DOWN(up), .iONE_SHOT(os), .iLOAD(ld),
        .iLOAD_MOD(lm), .iLOAD_VAL(lv),
        .oCOUNT(cnt), .oTC(tc), .oCARRY_OUT(co),
        .oWRAP(wrap), .oDONE(done)
    );

    contador_programable #(.WIDTH(W), .FIN_CUENTA(FIN)) u_lo (
        .iCLOCK(clk), .iRESET(c_rst), .iENABLE(c_en), .iCARRY_IN(1'b1),
        .iUP_DOWN(1'b1), .iONE_SHOT(1'b0), .iLOAD(1'b0),
        .iLOAD_MOD(8'd0), .iLOAD_VAL(8'd0),
        .oCOUNT(lo_cnt), .oTC(lo_tc), .oCARRY_OUT(lo_co),
        .oWRAP(lo_wrap), .oDONE(lo_done)
    );

    contador_programable #(.WIDTH(W), .FIN_CUENTA(FIN)) u_hi (
        .iCLOCK(clk), .iRESET(c_rst), .iENABLE(c_en), .iCARRY_IN(lo_co),
        .iUP_DOWN(1'b1), .iONE_SHOT(1'b0), .iLOAD(1'b0),
        .iLOAD_MOD(8'd0), .iLOAD_VAL(8'd0),
        .oCOUNT(hi_cnt), .oTC(hi_tc), .oCARRY_OUT(hi_co),
        .oWRAP(hi_wrap), .oDONE(hi_done)
    );

    typedef struct {
        bit casc;
        int cnt;
        bit tc;
        bit co;
        bit wrap;
        bit done;
        int lo;
        int hi;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state: plain integers, one-shot flag, pending pulse.
    int   m_cnt, m_mod;
    bit   m_halt, m_wrap;
    int   c_v;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d",
                     nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (sbq.size() != 0) begin
            x = sbq.pop_front();
            if (!x.casc) begin
                chk("count", 32'(cnt), x.cnt);
                chk("tc", 32'(tc), 32'(x.tc));
                chk("carry_out", 32'(co), 32'(x.co));
                chk("wrap", 32'(wrap), 32'(x.wrap));
                chk("done", 32'(done), 32'(x.done));
            end else begin
                chk("casc_lo", 32'(lo_cnt), x.lo);
                chk("casc_hi", 32'(hi_cnt), x.hi);
            end
        end
    end

    task automatic drive(input bit r, input bit e, input bit c,
                         input bit u, input bit o, input bit l,
                         input int lmv, input int lvv);
        exp_t x;
        bit   ee, t;
        int   nm;
        rst = r; en = e; cin = c; up = u; os = o; ld = l;
        lm  = 8'(lmv);
        lv  = 8'(lvv);
        ee  = e & c;
        t   = u ? (m_cnt == m_mod - 1) : (m_cnt == 0);
        x   = '{casc: 1'b0, cnt: m_cnt, tc: t, co: ee & t & !m_halt,
                wrap: m_wrap, done: m_halt, lo: 0, hi: 0};
        sbq.push_back(x);
        if (r) begin
            m_cnt = 0; m_mod = FIN; m_halt = 0; m_wrap = 0;
        end else if (l) begin
            nm     = (lmv % 256 == 0) ? 1 : lmv % 256;
            m_mod  = nm;
            m_cnt  = (lvv % 256 > nm - 1) ? nm - 1 : lvv % 256;
            m_halt = 0;
            m_wrap = 0;
        end else if (m_halt) begin
            m_wrap = 0;
            if (!o) m_halt = 0;
        end else if (ee) begin
            m_wrap = t;
            if (o && t) m_halt = 1;
            else if (u) m_cnt = (m_cnt + 1) % m_mod;
            else m_cnt = (m_cnt + m_mod - 1) % m_mod;
        end else begin
            m_wrap = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic casc_step(input bit r, input bit e);
        exp_t x;
        c_rst = r;
        c_en  = e;
        rst = 0; en = 0; ld = 0;
        x = '{casc: 1'b1, cnt: 0, tc: 0, co: 0, wrap: 0, done: 0,
              lo: c_v % 10, hi: c_v / 10};
        sbq.push_back(x);
        if (r) c_v = 0;
        else if (e) c_v = (c_v + 1) % 100;
        // main model sees an idle, non-loading cycle
        if (m_halt && !os) m_halt = 0;
        m_wrap = 0;
        @(posedge clk);
        #1;
    endtask

    bit rr, rl, re, rc, ru, ro;
    int rm, rv;

    initial begin
        rst = 1; en = 0; cin = 1; up = 1; os = 0; ld = 0; lm = '0; lv = '0;
        c_rst = 1; c_en = 0;
        @(posedge clk);
        #1;
        m_cnt = 0; m_mod = FIN; m_halt = 0; m_wrap = 0; c_v = 0;
        c_rst = 0;

        drive(1, 0, 1, 1, 0, 0, 0, 0);
        repeat (12) drive(0, 1, 1, 1, 0, 0, 0, 0);

        drive(1, 0, 1, 0, 0, 0, 0, 0);
        repeat (12) drive(0, 1, 1, 0, 0, 0, 0, 0);

        drive(0, 1, 1, 1, 0, 1, 5, 7);
        repeat (3) drive(0, 1, 1, 1, 0, 0, 0, 0);

        drive(0, 0, 1, 1, 1, 1, 4, 0);
        repeat (7) drive(0, 1, 1, 1, 1, 0, 0, 0);
        drive(0, 0, 1, 1, 1, 1, 4, 0);
        repeat (5) drive(0, 1, 1, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0, 0, 0);
        repeat (3) drive(0, 1, 1, 1, 0, 0, 0, 0);

        drive(0, 1, 1, 1, 0, 1, 0, 9);
        repeat (3) drive(0, 1, 1, 1, 0, 0, 0, 0);
        repeat (2) drive(0, 1, 1, 0, 0, 0, 0, 0);

        drive(0, 0, 1, 1, 0, 1, 20, 3);
        repeat (4) drive(0, 1, 1, 1, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 0, 1, 5, 2);
        repeat (2) drive(0, 1, 0, 1, 0, 0, 0, 0);
        repeat (2) drive(0, 1, 1, 1, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(0, 49) == 0);
            rl = ($urandom_range(0, 9) == 0);
            re = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 7) != 0);
            ru = 1'($urandom_range(0, 1));
            ro = ($urandom_range(0, 3) == 0);
            rm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 12));
            rv = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 12));
            drive(rr, re, rc, ru, ro, rl, rm, rv);
        end

        casc_step(1, 0);
        repeat (100) casc_step(0, 1);
        casc_step(0, 0);

        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
